// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t       : controller state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder.
//   sum   : x ^ y ^ cin
//   carry : majority(x, y, cin)
//   x, y  : operand bits
//   cin   : carry-in bit
module full_adder_cell (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y,
  input  logic cin
);

  assign sum   = x ^ y ^ cin;
  assign carry = (x & y) | (x & cin) | (y & cin);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first.
// {cout, sum} = a + b + cin after WIDTH RUN cycles, followed by a one-cycle
// done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load request, honoured in IDLE or DONE only
//   a, b, cin  : operands, sampled on the accepted start edge
//   busy       : high while in RUN
//   done       : high for the single DONE cycle
//   sum, cout  : held result, updated only on the completion edge
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sr, a_sr_next;
  logic [WIDTH-1:0]   b_sr, b_sr_next;
  // Holds the WIDTH-1 most recent result bits; the final bit joins at exit.
  logic [WIDTH-2:0]   acc_sr, acc_sr_next;
  logic               carry_ff, carry_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   sum_next;
  logic               cout_next;
  logic               busy_next, done_next;

  logic               fa_sum, fa_cout;
  logic [WIDTH-1:0]   shift_c;

  // Per-bit add of the current LSBs with the running carry.
  full_adder_cell u_fa (
    .sum   (fa_sum),
    .carry (fa_cout),
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .cin   (carry_ff)
  );

  // Accumulator view after inserting this cycle's sum bit at the MSB.
  assign shift_c = {fa_sum, acc_sr};

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    a_sr_next   = a_sr;
    b_sr_next   = b_sr;
    acc_sr_next = acc_sr;
    carry_next  = carry_ff;
    cnt_next    = cnt;
    sum_next    = sum;
    cout_next   = cout;

    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          a_sr_next  = a;
          b_sr_next  = b;
          carry_next = cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_sr_next   = {1'b0, a_sr[WIDTH-1:1]};
        b_sr_next   = {1'b0, b_sr[WIDTH-1:1]};
        acc_sr_next = shift_c[WIDTH-1:1];
        carry_next  = fa_cout;
        cnt_next    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          sum_next   = shift_c;
          cout_next  = fa_cout;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      acc_sr   <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      a_sr     <= a_sr_next;
      b_sr     <= b_sr_next;
      acc_sr   <= acc_sr_next;
      carry_ff <= carry_next;
      cnt      <= cnt_next;
      sum      <= sum_next;
      cout     <= cout_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule : serial_adder
